// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits.
// Holds a display word and selects one digit at a time. Each selected digit
// gets its nibble on hex_nibble and its active-low enable on digit_n.
// A new word is staged in a pending register and copied into the displayed
// shadow only on the frame-boundary edge, so one frame never mixes old and
// new digits.
module seven_seg_scan_ctrl #(
    parameter  int NUM_DIGITS  = 8,
    parameter  int REFRESH_DIV = 50000,
    parameter  int GUARD       = 2,
    parameter  int LZ_BLANK    = 1,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    output logic [3:0]              hex_nibble,
    output logic [NUM_DIGITS-1:0]   digit_n,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Nibble-addressable view of the word, so digit i is simply shadow[i].
    typedef logic [NUM_DIGITS-1:0][3:0] word_t;

    logic [CNT_W-1:0]      cnt;
    word_t                 shadow;
    word_t                 pending;
    logic                  pend_vld;
    logic                  last_cnt;
    logic                  wrap;
    logic                  guard_done;
    logic [NUM_DIGITS-1:0] lit_ok;

    // The last cycle of a slot, and the last cycle of the whole frame.
    assign last_cnt = (cnt == CNT_LAST);
    assign wrap     = last_cnt && (digit_idx == IDX_LAST);

    // Slot timer and digit index. frame_tick goes high on the cycle that
    // follows a wrap back to digit 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its pre-edge inputs whatever the statement order.
        if (reset) begin
            cnt        <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (last_cnt) begin
                cnt <= '0;
                if (digit_idx == IDX_LAST) digit_idx <= '0;
                else                       digit_idx <= digit_idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Tear-free word update. A load on an ordinary edge is parked in pending,
    // and the newest load wins. On the boundary edge, a simultaneous load goes
    // straight into shadow. Otherwise any parked word is committed.
    always_ff @(posedge clk) begin
        // NOTE: shadow and pending are plain flops, not a RAM, so they take a
        // reset. Otherwise the first frame after reset would show garbage.
        if (reset) begin
            shadow   <= '0;
            pending  <= '0;
            pend_vld <= 1'b0;
        end else if (wrap) begin
            if (load)          shadow <= value_in;
            else if (pend_vld) shadow <= pending;
            pend_vld <= 1'b0;
        end else if (load) begin
            pending  <= value_in;
            pend_vld <= 1'b1;
        end
    end

    // Leading-zero blanking. Scan from the top digit down. A digit may light
    // once any nibble at or above it is nonzero. Digit 0 may always light.
    always_comb begin
        logic nz;
        // NOTE: give every always_comb target a default first. A path that
        // leaves a variable unassigned would otherwise infer a latch.
        nz     = 1'b0;
        lit_ok = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz        = nz | (|shadow[i]);
            lit_ok[i] = nz || (i == 0) || (LZ_BLANK == 0);
        end
    end

    // The anti-ghost window covers the first GUARD cycles of every slot.
    assign guard_done = (int'(cnt) >= GUARD);

    // Output decode uses registered state only. load and value_in never reach
    // an output within the same cycle.
    always_comb begin
        hex_nibble = shadow[digit_idx];
        digit_n    = '1;
        if (guard_done && lit_ok[digit_idx]) digit_n[digit_idx] = 1'b0;
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl (4 digits, 4-cycle slots, 1 guard cycle).
// The bench tracks slot position (cnt, digit_idx) and frame_tick from its own
// cycle count. Expected nibbles and lit-digit masks are written out by hand for
// each displayed word.
module tb_seven_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  hex_nibble;
    logic [3:0]  digit_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // Bench-side slot position and expected frame_tick.
    int exp_cnt = 0;
    int exp_idx = 0;
    int exp_ft  = 0;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .GUARD      (1),
        .LZ_BLANK   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .value_in  (value_in),
        .hex_nibble(hex_nibble),
        .digit_n   (digit_n),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock. Outputs are sampled 1 ns after the rising edge.
    task automatic step();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) begin
            exp_cnt = 0;
            exp_idx = 0;
            exp_ft  = 0;
        end else begin
            exp_ft = (exp_cnt == RD - 1 && exp_idx == ND - 1) ? 1 : 0;
            if (exp_cnt == RD - 1) begin
                exp_cnt = 0;
                exp_idx = (exp_idx + 1) % ND;
            end else begin
                exp_cnt++;
            end
        end
    endtask

    task automatic goto_pos(input int idx, input int c);
        int n;
        n = 0;
        while (!(exp_idx == idx && exp_cnt == c) && n < 40) begin
            step();
            n++;
        end
        check("goto_bound", (exp_idx == idx && exp_cnt == c), 1);
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value_in = v;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Check one whole frame, starting at slot 0, cnt 0.
    // Argument lit gives the hand-computed set of digits that may light.
    task automatic check_frame(input string tag, input logic [15:0] word, input logic [3:0] lit);
        for (int k = 0; k < ND * RD; k++) begin
            logic [3:0] dn;
            dn = 4'hF;
            if (exp_cnt >= 1 && lit[exp_idx]) dn[exp_idx] = 1'b0;
            check({tag, "_hex"},  hex_nibble, word[4*exp_idx +: 4]);
            check({tag, "_dn"},   digit_n,    dn);
            check({tag, "_idx"},  digit_idx,  exp_idx);
            check({tag, "_tick"}, frame_tick, exp_ft);
            step();
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b1;
        load     = 1'b0;
        value_in = '0;
        step();
        step();
        check("rst_dn",   digit_n,    4'hF);
        check("rst_hex",  hex_nibble, 4'h0);
        check("rst_idx",  digit_idx,  2'd0);
        check("rst_tick", frame_tick, 1'b0);
        reset = 1'b0;

        // 1: no load. Only digit 0 lights, on cnt 1..3. The frame is 16 cycles.
        check_frame("t1", 16'h0000, 4'b0001);
        check("t1_tick16", frame_tick, 1'b1);

        // 2: a load mid-frame shows nothing until after the boundary edge.
        pulse_load(16'h12A4);
        check("t2_hold_hex", hex_nibble, 4'h0);
        goto_pos(3, 3);
        check("t2_pre_hex", hex_nibble, 4'h0);
        check("t2_pre_dn",  digit_n,    4'hF);
        step();
        check_frame("t2", 16'h12A4, 4'b1111);

        // 3: leading zeros above digit 1 are blanked.
        pulse_load(16'h00B0);
        goto_pos(0, 0);
        check_frame("t3", 16'h00B0, 4'b0011);

        // 4: the last load before the boundary wins.
        goto_pos(1, 0);
        pulse_load(16'h1111);
        goto_pos(2, 0);
        pulse_load(16'h2222);
        goto_pos(3, 3);
        check("t4_pre_hex", hex_nibble, 4'h0);
        check("t4_pre_dn",  digit_n,    4'hF);
        step();
        check_frame("t4", 16'h2222, 4'b1111);

        // 5: a load on the boundary edge replaces the pending word.
        goto_pos(1, 0);
        pulse_load(16'h5555);
        goto_pos(3, 3);
        pulse_load(16'h3333);
        check_frame("t5a", 16'h3333, 4'b1111);
        check_frame("t5b", 16'h3333, 4'b1111);

        // 6: reset mid-scan with a load pending.
        pulse_load(16'h7777);
        goto_pos(2, 1);
        reset = 1'b1;
        step();
        check("t6_dn",   digit_n,    4'hF);
        check("t6_idx",  digit_idx,  2'd0);
        check("t6_hex",  hex_nibble, 4'h0);
        check("t6_tick", frame_tick, 1'b0);
        reset = 1'b0;
        check_frame("t6a", 16'h0000, 4'b0001);
        check("t6_tick_wrap", frame_tick, exp_ft);
        check_frame("t6b", 16'h0000, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
